// File: rtl/aclint_memory.sv
// aclint_memory: single-hart ACLINT responder on the device side of the MMIO
// router. It answers Membus loads and stores at offsets relative to the ACLINT
// base. It holds msip, mtimecmp and the free-running mtime counter. It drives
// the machine software and timer interrupt lines and the time CSR source.
module aclint_memory #(
  parameter int XLEN      = 64,
  parameter int MTIME_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            membus_valid_i,
  output logic            membus_ready_o,
  input  logic [XLEN-1:0] membus_addr_i,
  input  logic            membus_wen_i,
  input  logic [63:0]     membus_wdata_i,
  input  logic [7:0]      membus_wmask_i,
  output logic            membus_rvalid_o,
  output logic [63:0]     membus_rdata_o,
  output logic            msip_o,
  output logic            mtip_o,
  output logic [63:0]     mtime_o
);

  // Word indices (offset >> 3) of the three mapped registers.
  localparam logic [12:0] IDX_MSIP     = 13'h0000;  // offset 0x0000
  localparam logic [12:0] IDX_MTIMECMP = 13'h0800;  // offset 0x4000
  localparam logic [12:0] IDX_MTIME    = 13'h17FF;  // offset 0xBFF8

  // The prescaler needs at least one bit, even when every cycle is a tick.
  localparam int          DIV_W    = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MTIME_DIV - 1);

  // Applies a byte-enable mask to a 64-bit register value.
  function automatic logic [63:0] merge_bytes(
    input logic [63:0] old_val,
    input logic [63:0] new_val,
    input logic [7:0]  mask
  );
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Architectural state.
  logic             msip_q,     msip_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [63:0]      mtime_q,    mtime_d;
  logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;

  // Response path, registered so the bus sees rvalid/rdata one cycle later.
  logic             rvalid_q,   rvalid_d;
  logic [63:0]      rdata_q,    rdata_d;

  // Decode results and timer tick.
  logic             addr_hi_zero;
  logic             addr_aligned;
  logic             sel_msip;
  logic             sel_mtimecmp;
  logic             sel_mtime;
  logic             tick;

  // Address decode: offset must fit in 16 bits and be 8-byte aligned.
  always_comb begin
    addr_hi_zero = ~(|membus_addr_i[XLEN-1:16]);
    addr_aligned = (membus_addr_i[2:0] == 3'b000);
    sel_msip     = 1'b0;
    sel_mtimecmp = 1'b0;
    sel_mtime    = 1'b0;
    if (addr_hi_zero && addr_aligned) begin
      case (membus_addr_i[15:3])
        IDX_MSIP:     sel_msip     = 1'b1;
        IDX_MTIMECMP: sel_mtimecmp = 1'b1;
        IDX_MTIME:    sel_mtime    = 1'b1;
        default: begin
          sel_msip     = 1'b0;
          sel_mtimecmp = 1'b0;
          sel_mtime    = 1'b0;
        end
      endcase
    end else begin
      sel_msip     = 1'b0;
      sel_mtimecmp = 1'b0;
      sel_mtime    = 1'b0;
    end
  end

  // Next-state logic: prescaler, mtime increment, register writes and read data.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    div_cnt_d  = div_cnt_q;
    rvalid_d   = membus_valid_i;
    rdata_d    = 64'd0;
    tick       = (div_cnt_q == DIV_LAST);

    // The prescaler free-runs; a bus write to mtime does not disturb it.
    if (tick) begin
      div_cnt_d = '0;
      mtime_d   = mtime_q + 64'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      mtime_d   = mtime_q;
    end

    if (membus_valid_i) begin
      if (membus_wen_i) begin
        // Writes respond with zero data. A write to mtime overrides the tick.
        rdata_d = 64'd0;
        if (sel_msip) begin
          if (membus_wmask_i[0]) begin
            msip_d = membus_wdata_i[0];
          end else begin
            msip_d = msip_q;
          end
        end else if (sel_mtimecmp) begin
          mtimecmp_d = merge_bytes(mtimecmp_q, membus_wdata_i, membus_wmask_i);
        end else if (sel_mtime) begin
          mtime_d = merge_bytes(mtime_q, membus_wdata_i, membus_wmask_i);
        end else begin
          rdata_d = 64'd0;
        end
      end else begin
        // Reads see the value held before any same-cycle update.
        if (sel_msip) begin
          rdata_d = {63'd0, msip_q};
        end else if (sel_mtimecmp) begin
          rdata_d = mtimecmp_q;
        end else if (sel_mtime) begin
          rdata_d = mtime_q;
        end else begin
          rdata_d = 64'd0;
        end
      end
    end else begin
      rdata_d = 64'd0;
    end
  end

  // State and response registers with synchronous reset; a reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q    <= 64'd0;
      div_cnt_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'd0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      div_cnt_q  <= div_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // No back-pressure: every valid request is accepted.
  assign membus_ready_o  = 1'b1;
  assign membus_rvalid_o = rvalid_q;
  assign membus_rdata_o  = rdata_q;

  // Interrupt lines and time source follow the registers directly.
  assign msip_o  = msip_q;
  assign mtip_o  = (mtime_q >= mtimecmp_q);
  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_aclint_memory.sv
// Directed self-checking bench for aclint_memory. It uses two instances: one
// with MTIME_DIV=1 for most scenarios and one with MTIME_DIV=4 for the
// prescaler. Inputs are driven and outputs are sampled 1 ns after each rising
// edge.
module tb_aclint_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid1;
  logic        valid4;
  logic        wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;

  logic        ready1, rvalid1, msip1, mtip1;
  logic [63:0] rdata1, mtime1;
  logic        ready4, rvalid4, msip4, mtip4;
  logic [63:0] rdata4, mtime4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aclint_memory #(.XLEN(64), .MTIME_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .membus_valid_i(valid1), .membus_ready_o(ready1), .membus_addr_i(addr),
    .membus_wen_i(wen), .membus_wdata_i(wdata), .membus_wmask_i(wmask),
    .membus_rvalid_o(rvalid1), .membus_rdata_o(rdata1),
    .msip_o(msip1), .mtip_o(mtip1), .mtime_o(mtime1)
  );

  aclint_memory #(.XLEN(64), .MTIME_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .membus_valid_i(valid4), .membus_ready_o(ready4), .membus_addr_i(addr),
    .membus_wen_i(wen), .membus_wdata_i(wdata), .membus_wmask_i(wmask),
    .membus_rvalid_o(rvalid4), .membus_rdata_o(rdata4),
    .msip_o(msip4), .mtip_o(mtip4), .mtime_o(mtime4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    wen = 1'b0; addr = 64'd0; wdata = 64'd0; wmask = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    wen = 1'b0; addr = 64'd0; wdata = 64'd0; wmask = 8'h00;
    step();
    step();
    rst = 1'b0;
    checks++; if (mtime1 !== 64'd0) begin errors++; $display("FAIL reset_mtime: got %h expected %h", mtime1, 64'd0); end
    checks++; if (rdata1 !== 64'd0 || rdata4 !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata1, rdata4); end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (rvalid1 !== 1'b0 || mtip1 !== 1'b0 || msip1 !== 1'b0 || ready1 !== 1'b1 ||
          rvalid4 !== 1'b0 || mtip4 !== 1'b0 || msip4 !== 1'b0 || ready4 !== 1'b1) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got rvalid=%b/%b mtip=%b/%b msip=%b/%b ready=%b/%b expected 0/0 0/0 0/0 1/1",
                 i, rvalid1, rvalid4, mtip1, mtip4, msip1, msip4, ready1, ready4);
      end
    end
    checks++; if (mtime1 !== 64'd10) begin errors++; $display("FAIL idle_mtime_div1: got %0d expected 10", mtime1); end
    checks++; if (mtime4 !== 64'd2) begin errors++; $display("FAIL idle_mtime_div4: got %0d expected 2", mtime4); end
  endtask

  task automatic test_msip();
    do_reset();
    valid1 = 1'b1; wen = 1'b1; addr = 64'h0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 8'h01;
    step();
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL msip_wr_rvalid: got %b expected 1", rvalid1); end
    checks++; if (rdata1 !== 64'd0) begin errors++; $display("FAIL msip_wr_rdata: got %h expected 0", rdata1); end
    checks++; if (msip1 !== 1'b1) begin errors++; $display("FAIL msip_level: got %b expected 1", msip1); end
    wen = 1'b0; wdata = 64'd0; wmask = 8'h00; addr = 64'h0;
    step();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'h1) begin errors++; $display("FAIL msip_rd: got rvalid=%b rdata=%h expected 1/%h", rvalid1, rdata1, 64'h1); end
    valid1 = 1'b0;
    step();
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL msip_rvalid_drop: got %b expected 0", rvalid1); end
  endtask

  task automatic test_unmapped();
    // msip is 1 from the previous test. Try a misaligned write to mtimecmp.
    valid1 = 1'b1; wen = 1'b1; addr = 64'h4004; wdata = 64'd0; wmask = 8'hFF;
    step();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'd0) begin errors++; $display("FAIL unmapped_wr: got rvalid=%b rdata=%h expected 1/0", rvalid1, rdata1); end
    // Offset 0x1_0000 aliases msip in the low bits but must read as unmapped.
    wen = 1'b0; wmask = 8'h00; addr = 64'h1_0000;
    step();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'd0) begin errors++; $display("FAIL unmapped_hi_rd: got rvalid=%b rdata=%h expected 1/0", rvalid1, rdata1); end
    addr = 64'h4000;
    step();
    checks++; if (rdata1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mtimecmp_untouched: got %h expected %h", rdata1, 64'hFFFF_FFFF_FFFF_FFFF); end
    valid1 = 1'b0;
    step();
  endtask

  task automatic test_timer();
    logic exp_mtip;
    do_reset();
    valid1 = 1'b1; wen = 1'b1; addr = 64'h4000; wdata = 64'd20; wmask = 8'hFF;
    step();
    valid1 = 1'b0; wen = 1'b0; wdata = 64'd0; wmask = 8'h00;
    checks++; if (mtime1 !== 64'd1 || mtip1 !== 1'b0) begin errors++; $display("FAIL timer_start: got mtime=%0d mtip=%b expected 1/0", mtime1, mtip1); end
    for (int k = 1; k <= 25; k++) begin
      step();
      exp_mtip = (k >= 19) ? 1'b1 : 1'b0;
      checks++;
      if (mtime1 !== 64'(k + 1) || mtip1 !== exp_mtip) begin
        errors++;
        $display("FAIL timer_mtip step %0d: got mtime=%0d mtip=%b expected %0d/%b", k, mtime1, mtip1, k + 1, exp_mtip);
      end
    end
    valid1 = 1'b1; wen = 1'b1; addr = 64'h4000; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 8'hFF;
    step();
    valid1 = 1'b0; wen = 1'b0; wmask = 8'h00;
    checks++; if (mtip1 !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b expected 0", mtip1); end
  endtask

  task automatic test_collision();
    do_reset();
    valid1 = 1'b1; wen = 1'b1; addr = 64'hBFF8; wdata = 64'h100; wmask = 8'hFF;
    step();
    checks++; if (mtime1 !== 64'h100) begin errors++; $display("FAIL mtime_full_wr: got %h expected %h", mtime1, 64'h100); end
    wdata = 64'hAA; wmask = 8'h01;
    step();
    valid1 = 1'b0; wen = 1'b0; wmask = 8'h00;
    checks++; if (mtime1 !== 64'h1AA) begin errors++; $display("FAIL mtime_partial_wr: got %h expected %h", mtime1, 64'h1AA); end
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 64'd0) begin errors++; $display("FAIL mtime_wr_resp: got rvalid=%b rdata=%h expected 1/0", rvalid1, rdata1); end
    step();
    checks++; if (mtime1 !== 64'h1AB) begin errors++; $display("FAIL mtime_after_wr: got %h expected %h", mtime1, 64'h1AB); end
  endtask

  task automatic test_prescaler();
    do_reset();
    valid4 = 1'b1; wen = 1'b1; addr = 64'hBFF8; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wmask = 8'hFF;
    step();
    valid4 = 1'b0; wen = 1'b0; wmask = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mtime4 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div4_hold_max %0d: got %h expected all ones", i, mtime4); end
      step();
    end
    checks++; if (mtime4 !== 64'd0) begin errors++; $display("FAIL div4_wrap: got %h expected 0", mtime4); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mtime4 !== 64'd0) begin errors++; $display("FAIL div4_hold_zero %0d: got %h expected 0", i, mtime4); end
    end
    step();
    checks++; if (mtime4 !== 64'd1) begin errors++; $display("FAIL div4_next_tick: got %h expected 1", mtime4); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [4];
    logic [63:0] exps  [4];
    addrs = '{64'h0, 64'h8, 64'h4000, 64'hBFF8};
    exps  = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3};
    do_reset();
    valid1 = 1'b1; wen = 1'b0; wmask = 8'h00; wdata = 64'd0;
    for (int i = 0; i < 4; i++) begin
      addr = addrs[i];
      step();
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== exps[i]) begin
        errors++;
        $display("FAIL b2b_rd %0d: got rvalid=%b rdata=%h expected 1/%h", i, rvalid1, rdata1, exps[i]);
      end
    end
    valid1 = 1'b0;
    step();
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", rvalid1); end
  endtask

  task automatic test_reset_mid_op();
    valid1 = 1'b1; wen = 1'b0; addr = 64'hBFF8; rst = 1'b1;
    step();
    rst = 1'b0; valid1 = 1'b0;
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 64'd0) begin errors++; $display("FAIL rst_mid_op: got rvalid=%b rdata=%h expected 0/0", rvalid1, rdata1); end
    checks++; if (mtime1 !== 64'd0) begin errors++; $display("FAIL rst_mid_mtime: got %h expected 0", mtime1); end
    step();
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %b expected 0", rvalid1); end
  endtask

  initial begin
    rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
    wen = 1'b0; addr = 64'd0; wdata = 64'd0; wmask = 8'h00;
    test_reset();
    test_msip();
    test_unmapped();
    test_timer();
    test_collision();
    test_prescaler();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
